fwd_history_unit: RTL

- Parametrised operand-forwarding unit for the in-order RISC-V integer pipeline; successor to the fixed 2-source, 3-way forwarding mux.
- Keeps a registered history of the last DEPTH writeback-bound results after EX, each tagged with rd and a data-ready flag.
- Gives every ID/EX source operand the youngest matching value, or the register-file value when nothing matches.
- Raises a load-use stall when the youngest match is a load whose data has not yet returned.

---
 rtl/fwd_pkg.sv | 12 +
 rtl/fwd_lookup.sv | 39 +++
 rtl/fwd_history_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared widths and the history slot record for the operand-forwarding unit.
package fwd_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int REG_W_DEF = 5;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] rd;
    logic                 ready;
    logic [XLEN_DEF-1:0]  data;
  } fwd_slot_t;
endpackage

// File: rtl/fwd_lookup.sv
// Single-operand priority search over the history slots, youngest (slot0) first.
module fwd_lookup
  import fwd_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int REG_W = REG_W_DEF,
  parameter int DEPTH = 3
) (
  input  logic [DEPTH-1:0]            slot_valid,
  input  logic [DEPTH-1:0]            slot_ready,
  input  logic [DEPTH-1:0][REG_W-1:0] slot_rd,
  input  logic [DEPTH-1:0][XLEN-1:0]  slot_data,
  input  logic [REG_W-1:0]            rs,
  input  logic [XLEN-1:0]             rf_data,
  output logic [XLEN-1:0]             data,
  output logic                        hit,
  output logic                        pend
);
  logic found;

  always_comb begin
    found = 1'b0;
    data  = rf_data;
    hit   = 1'b0;
    pend  = 1'b0;
    // The first match decides; an older ready copy never bypasses a pending load.
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && (rs != '0) && slot_valid[k] && (slot_rd[k] == rs)) begin
        found = 1'b1;
        if (slot_ready[k]) begin
          hit  = 1'b1;
          data = slot_data[k];
        end else begin
          pend = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/fwd_history_unit.sv
// Operand forwarding from a DEPTH-deep post-EX result history with load-use stall.
// Optional FWD_STATS_EN adds hit/stall counters.
module fwd_history_unit
  import fwd_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_W   = REG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic                     ex_we,
  input  logic                     ex_is_load,
  input  logic [REG_W-1:0]         ex_rd,
  input  logic [XLEN-1:0]          ex_result,
  input  logic                     ld_rsp_valid,
  input  logic [XLEN-1:0]          ld_rsp_data,
  input  logic [NUM_SRC*REG_W-1:0] src_rs,
  input  logic [NUM_SRC*XLEN-1:0]  src_rf_data,
  output logic [NUM_SRC*XLEN-1:0]  src_data,
  output logic [NUM_SRC-1:0]       src_fwd_hit,
  output logic                     stall,
  output logic                     ld_err
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_stalls
`endif
);
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0]            ready_q, ready_d;
  logic [DEPTH-1:0][REG_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][XLEN-1:0]  data_q, data_d;
  logic                        ld_err_q, ld_err_d;
  logic                        fill_done;
  logic [NUM_SRC-1:0]          pend;

  always_comb begin
    valid_d[0] = ex_valid & ex_we & (ex_rd != '0);
    rd_d[0]    = ex_rd;
    ready_d[0] = ~ex_is_load;
    data_d[0]  = ex_result;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
      ready_d[k] = ready_q[k-1];
      data_d[k]  = data_q[k-1];
    end
    // Responses return in program order, so they complete the oldest pending
    // entry after the shift; the incoming slot0 only qualifies when nothing older waits.
    fill_done = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (ld_rsp_valid && !fill_done && valid_d[k] && !ready_d[k]) begin
        ready_d[k] = 1'b1;
        data_d[k]  = ld_rsp_data;
        fill_done  = 1'b1;
      end
    end
    ld_err_d = ld_err_q
             | (valid_q[DEPTH-1] & ~ready_q[DEPTH-1])
             | (ld_rsp_valid & ~fill_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      ready_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      ld_err_q <= ld_err_d;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_lookup #(.XLEN(XLEN), .REG_W(REG_W), .DEPTH(DEPTH)) u_lookup (
      .slot_valid (valid_q),
      .slot_ready (ready_q),
      .slot_rd    (rd_q),
      .slot_data  (data_q),
      .rs         (src_rs[i*REG_W +: REG_W]),
      .rf_data    (src_rf_data[i*XLEN +: XLEN]),
      .data       (src_data[i*XLEN +: XLEN]),
      .hit        (src_fwd_hit[i]),
      .pend       (pend[i])
    );
  end

  assign stall  = |pend;
  assign ld_err = ld_err_q;

`ifdef FWD_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_hits_d = stat_hits_q;
    for (int i = 0; i < NUM_SRC; i++) stat_hits_d = stat_hits_d + 32'(src_fwd_hit[i]);
    stat_stalls_d = stat_stalls_q + 32'(stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_q   <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_stalls = stat_stalls_q;
`endif
endmodule
